// File: rtl/shared_mem_responder.sv
// Memory-side responder for the shared CPU-cell bus: four-phase read/write handshake
// onto an internal synchronous word RAM, with wait states and a write-protected low region.
module shared_mem_responder #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned MEM_AW      = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_q,
   input  logic              write_q,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              read_dn,
   output logic              write_dn,
   output logic              bus_busy,
   input  logic [ADDR_W-1:0] addr_unmodificable_b,
   output logic              err
);
   localparam int unsigned Depth = 1 << MEM_AW;

   typedef enum logic [1:0] {StIdle, StWait, StAck, StRelease} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              is_read_q, both_q;
   logic              busy_q, busy_d;
   logic              read_dn_q, read_dn_d;
   logic              write_dn_q, write_dn_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] data_out_q;
   logic [DATA_W-1:0] mem [Depth];

   logic              req, accept, commit, in_range, blocked, mem_we;
   logic [MEM_AW-1:0] idx;

   assign req      = read_q | write_q;
   assign accept   = (state_q == StIdle) && req;
   assign commit   = (state_q == StWait) && (cnt_q == 4'd0);
   assign in_range = (addr_q[ADDR_W-1:MEM_AW] == '0);
   assign blocked  = (addr_q < addr_unmodificable_b);
   assign idx      = addr_q[MEM_AW-1:0];
   // A reset on the commit edge must still suppress the write.
   assign mem_we   = commit && !is_read_q && in_range && !blocked && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         busy_q     <= 1'b0;
         read_dn_q  <= 1'b0;
         write_dn_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         read_dn_q  <= read_dn_d;
         write_dn_q <= write_dn_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               state_d = StWait;
               cnt_d   = 4'(WAIT_STATES);
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StAck;
            else               cnt_d   = cnt_q - 4'd1;
         end
         // Requester may already have dropped its request during the ack cycle.
         StAck:     state_d = req ? StRelease : StIdle;
         StRelease: if (!req) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_d = busy_q;
      if (accept) busy_d = 1'b1;
      else if ((state_q == StAck || state_q == StRelease) && !req) busy_d = 1'b0;
      read_dn_d  = commit && is_read_q;
      write_dn_d = commit && !is_read_q;
      err_d      = commit && (both_q || !in_range || (!is_read_q && blocked));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         is_read_q <= 1'b0;
         both_q    <= 1'b0;
      end else if (accept) begin
         addr_q    <= addr_in;
         wdata_q   <= data_in;
         is_read_q <= read_q;
         both_q    <= read_q & write_q;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= wdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst)                                 data_out_q <= '0;
      else if (commit && is_read_q && in_range) data_out_q <= mem[idx];
      else                                     data_out_q <= '0;
   end

   assign data_out = data_out_q;
   assign read_dn  = read_dn_q;
   assign write_dn = write_dn_q;
   assign bus_busy = busy_q;
   assign err      = err_q;

endmodule

// File: tb/tb_shared_mem_responder.sv
// Scoreboard bench for shared_mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0
// instance share the address/data/limit lines, each with its own request lines.
module tb_shared_mem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rq = 1'b0, wq = 1'b0, rq0 = 1'b0, wq0 = 1'b0;
   logic [31:0] addr = '0, prot = '0;
   logic [63:0] wdata = '0;
   logic [63:0] dout, dout0;
   logic        rdn, wdn, busy, errs, rdn0, wdn0, busy0, errs0;

   logic        sel = 1'b0;
   logic [63:0] o_data;
   logic        o_rdn, o_wdn, o_busy, o_err;

   typedef struct {
      logic        rd;
      logic        err;
      logic [63:0] data;
   } exp_t;
   exp_t        sb[$];
   logic [63:0] model  [1024];
   logic [63:0] model0 [1024];
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   shared_mem_responder #(.ADDR_W(32), .DATA_W(64), .MEM_AW(10), .WAIT_STATES(2)) u_dut (
      .clk(clk), .rst(rst), .read_q(rq), .write_q(wq), .addr_in(addr), .data_in(wdata),
      .data_out(dout), .read_dn(rdn), .write_dn(wdn), .bus_busy(busy),
      .addr_unmodificable_b(prot), .err(errs)
   );

   shared_mem_responder #(.ADDR_W(32), .DATA_W(64), .MEM_AW(10), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .read_q(rq0), .write_q(wq0), .addr_in(addr), .data_in(wdata),
      .data_out(dout0), .read_dn(rdn0), .write_dn(wdn0), .bus_busy(busy0),
      .addr_unmodificable_b(prot), .err(errs0)
   );

   always_comb begin
      o_data = sel ? dout0 : dout;
      o_rdn  = sel ? rdn0  : rdn;
      o_wdn  = sel ? wdn0  : wdn;
      o_busy = sel ? busy0 : busy;
      o_err  = sel ? errs0 : errs;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full four-phase transfer; hold = extra cycles the request stays high after dn.
   task automatic xfer(input logic s, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [63:0] d, input int hold);
      exp_t e;
      logic in_r;
      int   ws, n;
      sel  = s;
      ws   = s ? 0 : 2;
      in_r = (a[31:10] == 22'd0);
      e.rd   = rd;
      e.err  = (rd && wr) || !in_r || (!rd && a < prot);
      e.data = '0;
      if (rd && in_r) e.data = s ? model0[a[9:0]] : model[a[9:0]];
      if (!rd && !e.err) begin
         if (s) model0[a[9:0]] = d;
         else   model[a[9:0]]  = d;
      end
      sb.push_back(e);
      addr  = a;
      wdata = d;
      if (s) begin rq0 = rd; wq0 = wr; end
      else   begin rq  = rd; wq  = wr; end
      @(posedge clk); #1;
      check_eq("accept_busy", 64'(o_busy), 64'd1);
      addr  = ~a;
      wdata = ~d;
      n = 0;
      while (!(o_rdn || o_wdn) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("dn_latency", 64'(n), 64'(ws + 1));
      e = sb.pop_front();
      check_eq("read_dn", 64'(o_rdn), 64'(e.rd));
      check_eq("write_dn", 64'(o_wdn), 64'(!e.rd));
      check_eq("err", 64'(o_err), 64'(e.err));
      check_eq("data_out", o_data, e.data);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq("hold_no_dn", 64'(o_rdn | o_wdn), 64'd0);
         check_eq("hold_busy", 64'(o_busy), 64'd1);
      end
      rq = 1'b0; wq = 1'b0; rq0 = 1'b0; wq0 = 1'b0;
      @(posedge clk); #1;
      check_eq("post_dn", 64'(o_rdn | o_wdn | o_err), 64'd0);
      check_eq("post_data", o_data, 64'd0);
      check_eq("busy_fall", 64'(o_busy), 64'd0);
   endtask

   initial begin
      int n;
      logic [31:0] ra;
      logic [63:0] rv;

      // Reset with a pending read: nothing may respond.
      rst = 1'b1;
      rq  = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check_eq("rst_busy", 64'(busy), 64'd0);
         check_eq("rst_dn", 64'(rdn | wdn), 64'd0);
         check_eq("rst_err", 64'(errs), 64'd0);
         check_eq("rst_data", dout, 64'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_release_accept", 64'(busy), 64'd1);
      n = 0;
      while (!rdn && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("rst_release_read_dn", 64'(rdn), 64'd1);
      rq = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_release_busy_fall", 64'(busy), 64'd0);

      prot = 32'h0;
      xfer(1'b0, 1'b0, 1'b1, 32'h000, 64'hA5A5_0000_1111_2222, 0);
      xfer(1'b0, 1'b0, 1'b1, 32'h010, 64'h0123_4567_89AB_CDEF, 0);
      xfer(1'b0, 1'b0, 1'b1, 32'h01F, 64'h0000_0000_DEAD_BEEF, 0);
      xfer(1'b0, 1'b0, 1'b1, 32'h030, 64'h3030_3030_3030_3030, 0);
      xfer(1'b0, 1'b1, 1'b0, 32'h010, 64'h0, 0);
      xfer(1'b0, 1'b1, 1'b0, 32'h000, 64'h0, 0);

      // Reset before the commit edge: the write must not land and no dn appears.
      sel = 1'b0;
      addr = 32'h030; wdata = 64'hBAD0_BAD0_BAD0_BAD0; wq = 1'b1;
      @(posedge clk); #1;
      check_eq("abort_accept", 64'(busy), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_no_dn", 64'(wdn | rdn), 64'd0);
      wq = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_no_dn2", 64'(wdn | rdn), 64'd0);
      xfer(1'b0, 1'b1, 1'b0, 32'h030, 64'h0, 0);

      prot = 32'h20;
      xfer(1'b0, 1'b0, 1'b1, 32'h01F, 64'hFF, 0);
      xfer(1'b0, 1'b1, 1'b0, 32'h01F, 64'h0, 0);
      xfer(1'b0, 1'b0, 1'b1, 32'h020, 64'h2020_2020_0000_0001, 0);
      xfer(1'b0, 1'b1, 1'b0, 32'h020, 64'h0, 0);

      prot = 32'h0;
      xfer(1'b0, 1'b1, 1'b0, 32'h400, 64'h0, 0);
      xfer(1'b0, 1'b0, 1'b1, 32'h400, 64'h5555_5555_5555_5555, 0);
      xfer(1'b0, 1'b1, 1'b0, 32'h000, 64'h0, 0);

      xfer(1'b0, 1'b1, 1'b0, 32'h010, 64'h0, 5);

      // Zero-wait-state instance: simultaneous requests resolve as a flagged read.
      xfer(1'b1, 1'b0, 1'b1, 32'h005, 64'hF00D_F00D_0000_0005, 0);
      xfer(1'b1, 1'b1, 1'b1, 32'h005, 64'h1234_0000_0000_9999, 0);
      xfer(1'b1, 1'b1, 1'b0, 32'h005, 64'h0, 0);

      for (int i = 0; i < 6; i++) begin
         ra = 32'($urandom_range(0, 1023));
         rv = {$urandom, $urandom};
         xfer(1'b0, 1'b0, 1'b1, ra, rv, i % 3);
         xfer(1'b0, 1'b1, 1'b0, ra, 64'h0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
